// File: rtl/job_dispatcher.sv
// job_dispatcher
//   Dynamic work scheduler for the 16-core jimmy cluster. Idle cores raise
//   req; a round-robin arbiter grants one core per cycle with the next
//   [job_start, job_end] address chunk. Once the address space is exhausted,
//   further requests are answered with job_none so the core halts. Per-job
//   result counts reported by the cores are summed into total. Run cycles are
//   counted in cycles. done is raised once every issued job has reported.
//
// Ports
//   clk        : system clock, all logic on the rising edge
//   reset      : synchronous active-high reset, clears all state
//   start      : one-cycle pulse, begins a run from IDLE or DONE
//   req        : per-core job request (level, held until ack seen)
//   res_valid  : per-core one-cycle pulse, result of current job valid
//   res_count  : packed per-core result counts, lane i = [i*CNT_W +: CNT_W]
//   ack        : one-hot grant, high for exactly one cycle
//   job_start  : first address of the granted job (valid with ack)
//   job_end    : last address (inclusive) of the granted job (valid with ack)
//   job_none   : with ack, no work left and the core should halt
//   total      : accumulated result count for the current run (wraps)
//   cycles     : clock cycles spent in RUN+DRAIN, saturating at 0xFFFF
//   busy       : high in RUN and DRAIN
//   done       : high in DONE until the next start or reset
//   err        : sticky, a result arrived from a core with no outstanding job
module job_dispatcher #(
  parameter int CORES     = 16,
  parameter int RANGE_MAX = 256,
  parameter int CHUNK     = 16,
  parameter int CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CORES-1:0]       req,
  input  logic [CORES-1:0]       res_valid,
  input  logic [CORES*CNT_W-1:0] res_count,
  output logic [CORES-1:0]       ack,
  output logic [7:0]             job_start,
  output logic [7:0]             job_end,
  output logic                   job_none,
  output logic [15:0]            total,
  output logic [15:0]            cycles,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int          PTR_W     = (CORES > 1) ? $clog2(CORES) : 1;
  localparam int unsigned CORES_U   = CORES;
  localparam logic [8:0]  CHUNK_9   = 9'(CHUNK);
  localparam logic [8:0]  RANGE_END = 9'(RANGE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [8:0]       next_base, next_base_n;
  logic [CORES-1:0] outstanding, outstanding_n;
  logic [PTR_W-1:0] ptr, ptr_n;

  logic [CORES-1:0] ack_n;
  logic [7:0]       job_start_n, job_end_n;
  logic             job_none_n;
  logic [15:0]      total_n, cycles_n;
  logic             err_n;

  logic [CORES-1:0] eligible;
  logic [CORES-1:0] accepted;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_found;
  logic [15:0]      total_add;
  logic [8:0]       base_after;

  // Index base+off, wrapped into the core range.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int unsigned off);
    int unsigned sum;
    sum = (32'(base) + off) % CORES_U;
    return PTR_W'(sum);
  endfunction

  always_comb begin
    state_n       = state;
    next_base_n   = next_base;
    outstanding_n = outstanding;
    ptr_n         = ptr;
    ack_n         = '0;
    job_start_n   = '0;
    job_end_n     = '0;
    job_none_n    = 1'b0;
    total_n       = total;
    cycles_n      = cycles;
    err_n         = err;
    cand          = '0;
    grant_idx     = ptr;
    grant_found   = 1'b0;
    total_add     = '0;
    base_after    = next_base + CHUNK_9;

    // The core acked last cycle may still hold req high, so it is masked
    // out for one cycle to avoid handing it a second job by mistake.
    eligible = req & ~ack;
    for (int unsigned k = 1; k <= CORES_U; k++) begin
      cand = wrap_idx(ptr, k);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end

    // All accepted lanes are summed in the same cycle.
    accepted = res_valid & outstanding;
    for (int i = 0; i < CORES; i++) begin
      if (accepted[i]) begin
        total_add = total_add + 16'(res_count[i*CNT_W +: CNT_W]);
      end
    end

    case (state)
      IDLE, DONE: begin
        if (res_valid != '0) begin
          err_n = 1'b1;
        end
        // Starting a run wipes the per-run state; the rr pointer is kept so
        // fairness carries over between runs.
        if (start) begin
          state_n       = RUN;
          next_base_n   = '0;
          total_n       = '0;
          cycles_n      = '0;
          outstanding_n = '0;
          err_n         = 1'b0;
        end
      end
      RUN, DRAIN: begin
        if (cycles != 16'hFFFF) begin
          cycles_n = cycles + 16'd1;
        end
        total_n = total + total_add;
        if ((res_valid & ~outstanding) != '0) begin
          err_n = 1'b1;
        end
        // Result clear first, then grant set, so a core reporting and
        // being re-granted in the same cycle stays outstanding.
        outstanding_n = outstanding & ~accepted;
        if (grant_found) begin
          ack_n[grant_idx] = 1'b1;
          ptr_n            = grant_idx;
          if (state == RUN) begin
            job_start_n                = next_base[7:0];
            job_end_n                  = next_base[7:0] + 8'(CHUNK - 1);
            next_base_n                = base_after;
            outstanding_n[grant_idx]   = 1'b1;
            if (base_after == RANGE_END) begin
              state_n = DRAIN;
            end
          end else begin
            job_none_n = 1'b1;
          end
        end
        if ((state == DRAIN) && (outstanding == '0) && (res_valid == '0)) begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      next_base   <= '0;
      outstanding <= '0;
      ptr         <= PTR_W'(CORES - 1);
      ack         <= '0;
      job_start   <= '0;
      job_end     <= '0;
      job_none    <= 1'b0;
      total       <= '0;
      cycles      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      next_base   <= next_base_n;
      outstanding <= outstanding_n;
      ptr         <= ptr_n;
      ack         <= ack_n;
      job_start   <= job_start_n;
      job_end     <= job_end_n;
      job_none    <= job_none_n;
      total       <= total_n;
      cycles      <= cycles_n;
      busy        <= (state_n == RUN) || (state_n == DRAIN);
      done        <= (state_n == DONE);
      err         <= err_n;
    end
  end

endmodule
